// File: rtl/fifo_pkt_drain.sv
// Drains an upstream show-ahead FIFO into a valid/ready packet stream.
// A two-entry skid buffer keeps the pop request free of any out_ready path.
module fifo_pkt_drain #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             flush,
    output logic [15:0]      pkt_count
);

    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic push_s;
    logic pop_s;
    logic valid_s;
    logic last_s;

    // Handshake decode; reset gates the pop so an asserted reset never drains the FIFO.
    always_comb begin
        valid_s = (occ_q != 2'd0);
        push_s  = reset && !fifo_empty && (occ_q != 2'd2);
        pop_s   = valid_s && out_ready;
        last_s  = valid_s && ((beat_cnt_q == LAST_BEAT) || flush_pend_q || flush);
    end

    // Two-entry in-order buffer: head is always the presented beat.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push_s, pop_s})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    head_d = fifo_rd_data;
                end else begin
                    tail_d = fifo_rd_data;
                end
            end
            2'b01: begin
                occ_d  = occ_q - 2'd1;
                head_d = tail_q;
            end
            2'b11: begin
                // Occupancy holds; the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = fifo_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rd_data;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Packet framing: beat position, early-close request and packet tally.
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        flush_pend_d = flush_pend_q;
        pkt_count_d  = pkt_count_q;
        if (pop_s) begin
            flush_pend_d = 1'b0;
            if (last_s) begin
                beat_cnt_d  = 8'd0;
                pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                beat_cnt_d  = beat_cnt_q + 8'd1;
                pkt_count_d = pkt_count_q;
            end
        end else if (flush && (valid_s || (beat_cnt_q != 8'd0))) begin
            // A flush with nothing started and nothing presented would frame an empty packet.
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q        <= 2'd0;
            head_q       <= '0;
            tail_q       <= '0;
            beat_cnt_q   <= 8'd0;
            flush_pend_q <= 1'b0;
            pkt_count_q  <= 16'd0;
        end else begin
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign fifo_rd_en = push_s;
    assign out_valid  = valid_s;
    assign out_data   = head_q;
    assign out_last   = last_s;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Self-checking bench for fifo_pkt_drain: vector table, directed corner
// sequences and randomized traffic against a queue-level reference model.
module tb_fifo_pkt_drain;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             flush;
    logic [15:0]      pkt_count;

    always #5 clk = ~clk;

    fifo_pkt_drain #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .flush        (flush),
        .pkt_count    (pkt_count)
    );

    int checks = 0;
    int errors = 0;

    // Upstream FIFO contents and reference model state.
    logic [7:0]  src_q[$];
    logic [7:0]  mdl_q[$];
    int          mdl_beat;
    logic        mdl_fpend;
    logic [15:0] mdl_pkt;

    // Beats the DUT actually handed over, as observed on its ports.
    logic [7:0] acc_data[$];
    logic       acc_last[$];
    int         acc_cyc[$];
    int         n_acc;
    int         cyc = 0;

    typedef struct {
        logic        empty;
        logic [7:0]  data;
        logic        ready;
        logic        flsh;
        logic        e_rd;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_last;
        logic [15:0] e_pkt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        if (src_q.size() == 0) begin
            fifo_empty   = 1'b1;
            fifo_rd_data = 8'($urandom);
        end else begin
            fifo_empty   = 1'b0;
            fifo_rd_data = src_q[0];
        end
    endtask

    task automatic clear_model();
        mdl_q.delete();
        mdl_beat  = 0;
        mdl_fpend = 1'b0;
        mdl_pkt   = 16'd0;
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_last.delete();
        acc_cyc.delete();
        n_acc = 0;
    endtask

    // One clock cycle: inputs already driven at posedge+1; check at posedge+3.
    task automatic tick();
        logic e_rd, e_valid, e_last, m_acc, d_acc;
        logic [7:0] d_data;
        logic d_last;
        #2;
        e_valid = (mdl_q.size() > 0);
        e_rd    = reset && (src_q.size() > 0) && (mdl_q.size() < 2);
        e_last  = e_valid && ((mdl_beat == PKT_LEN - 1) || mdl_fpend || flush);
        m_acc   = e_valid && out_ready;
        chk("rd_en", 32'(fifo_rd_en), 32'(e_rd));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        if (e_valid) chk("out_data", 32'(out_data), 32'(mdl_q[0]));
        chk("out_last", 32'(out_last), 32'(e_last));
        chk("pkt_count", 32'(pkt_count), 32'(mdl_pkt));
        d_acc  = out_valid && out_ready;
        d_data = out_data;
        d_last = out_last;
        @(posedge clk);
        cyc++;
        if (d_acc === 1'b1) begin
            acc_data.push_back(d_data);
            acc_last.push_back(d_last);
            acc_cyc.push_back(cyc);
            n_acc++;
        end
        if (m_acc) begin
            void'(mdl_q.pop_front());
            mdl_fpend = 1'b0;
            if (e_last) begin
                mdl_beat = 0;
                mdl_pkt  = mdl_pkt + 16'd1;
            end else begin
                mdl_beat = mdl_beat + 1;
            end
        end else if (flush && (e_valid || mdl_beat != 0)) begin
            mdl_fpend = 1'b1;
        end
        if (e_rd) mdl_q.push_back(src_q.pop_front());
        #1;
        drive_src();
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        drive_src();
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_ffff;
        bit fl_done;
        logic [7:0] first_after;
        logic [15:0] pkt_before;

        // Reset state with aggressive inputs applied.
        reset = 1'b0; fifo_empty = 1'b0; fifo_rd_data = 8'h55;
        out_ready = 1'b1; flush = 1'b1;
        clear_model(); clear_log();
        #12;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        flush = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        fifo_empty = 1'b1;

        // Backpressure, occupancy limit, framing and ignored flush.
        tbl[0]  = '{1'b0, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 1'b1, 16'd0};
        tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[11] = '{1'b0, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 16'd1};
        for (int i = 0; i < 13; i++) begin
            fifo_empty   = tbl[i].empty;
            fifo_rd_data = tbl[i].data;
            out_ready    = tbl[i].ready;
            flush        = tbl[i].flsh;
            #2;
            chk($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].e_last));
            chk($sformatf("tbl%0d_pkt", i), 32'(pkt_count), 32'(tbl[i].e_pkt));
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        src_q.delete();
        do_reset();

        // Streaming eight words, two full packets, one beat per cycle.
        clear_log();
        for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
        out_ready = 1'b1;
        drive_src();
        for (int t = 0; t < 40 && n_acc < 8; t++) tick();
        chk("stream_count", 32'(n_acc), 32'd8);
        for (int i = 0; i < 8 && i < acc_data.size(); i++) begin
            chk($sformatf("stream_data%0d", i), 32'(acc_data[i]), 32'(i + 1));
            chk($sformatf("stream_last%0d", i), 32'(acc_last[i]), 32'((i == 3) || (i == 7)));
        end
        if (acc_cyc.size() >= 8) chk("stream_rate", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
        chk("stream_pkt", 32'(pkt_count), 32'd2);

        // Flush after two beats closes a 3-beat packet; the next is full length.
        clear_log();
        fl_done = 1'b0;
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
        drive_src();
        for (int t = 0; t < 40 && n_acc < 8; t++) begin
            flush = (n_acc == 2) && !fl_done;
            if (flush) fl_done = 1'b1;
            tick();
            flush = 1'b0;
        end
        chk("flush_count", 32'(n_acc), 32'd8);
        for (int i = 0; i < 8 && i < acc_last.size(); i++)
            chk($sformatf("flush_last%0d", i), 32'(acc_last[i]), 32'((i == 2) || (i == 6)));
        chk("flush_pkt", 32'(pkt_count), 32'd4);

        // Asynchronous reset with two beats buffered and beat_cnt at 2.
        clear_log();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h20 + i));
        drive_src();
        for (int t = 0; t < 20 && n_acc < 2; t++) tick();
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("arst_pkt", 32'(pkt_count), 32'd0);
        clear_model();
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        drive_src();
        first_after = src_q[0];
        #1;
        chk("arst_no_stale", 32'(out_valid), 32'd0);
        #(-0);
        clear_log();
        for (int t = 0; t < 20 && n_acc < 4; t++) tick();
        chk("arst_count", 32'(n_acc), 32'd4);
        if (acc_data.size() > 0) chk("arst_first", 32'(acc_data[0]), 32'(first_after));
        for (int i = 0; i < 4 && i < acc_last.size(); i++)
            chk($sformatf("arst_last%0d", i), 32'(acc_last[i]), 32'(i == 3));

        // Empty FIFO: no pops, no beats, no packet count change.
        src_q.delete();
        drive_src();
        for (int t = 0; t < 4; t++) tick();
        pkt_before = mdl_pkt;
        for (int t = 0; t < 6; t++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("empty_pkt", 32'(pkt_count), 32'(pkt_before));

        // Randomized traffic against the model.
        for (int t = 0; t < 3000; t++) begin
            if (src_q.size() < 6 && $urandom_range(0, 2) != 0) src_q.push_back(8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            drive_src();
            tick();
        end
        flush = 1'b0;

        // 65536 single-beat packets wrap the packet counter back to zero.
        src_q.delete();
        do_reset();
        clear_log();
        out_ready = 1'b1;
        flush     = 1'b1;
        seen_ffff = 1'b0;
        for (int t = 0; t < 66000 && n_acc < 65536; t++) begin
            while (src_q.size() < 4) src_q.push_back(8'($urandom));
            drive_src();
            tick();
            if (n_acc == 65535 && !seen_ffff) begin
                seen_ffff = 1'b1;
                chk("wrap_ffff", 32'(pkt_count), 32'h0000_FFFF);
            end
        end
        flush = 1'b0;
        chk("wrap_count", 32'(n_acc), 32'd65536);
        chk("wrap_zero", 32'(pkt_count), 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
